// File: rtl/syscall_responder_pkg.sv
// ----------------------------------------------------------------------------
// syscall_responder_pkg
// Purpose : shared definitions for the SYSCALL service block. This package
//           holds the FSM state encoding, the default $v0 service codes, the
//           datapath widths, and a helper that classifies a $v0 value into a
//           service.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package syscall_responder_pkg;

   // Datapath widths
   localparam int SYS_DATA_W  = 32;
   localparam int SYS_CHAR_W  = 8;
   localparam int SYS_UNK_W   = 8;
   localparam int SYS_PAUSE_W = 16;

   // Default $v0 service codes (MARS-style numbering)
   localparam logic [SYS_DATA_W-1:0] SYS_CODE_HALT  = 32'd10;
   localparam logic [SYS_DATA_W-1:0] SYS_CODE_DISP  = 32'd34;
   localparam logic [SYS_DATA_W-1:0] SYS_CODE_PUTC  = 32'd11;
   localparam logic [SYS_DATA_W-1:0] SYS_CODE_PAUSE = 32'd32;

   // Service FSM states
   typedef enum logic [2:0] {
      SYS_ST_IDLE  = 3'd0,
      SYS_ST_PAUSE = 3'd1,
      SYS_ST_PRINT = 3'd2,
      SYS_ST_HALT  = 3'd3,
      SYS_ST_DONE  = 3'd4
   } sys_state_t;

   // Decoded service selected by $v0
   typedef enum logic [2:0] {
      SYS_SVC_UNK   = 3'd0,
      SYS_SVC_HALT  = 3'd1,
      SYS_SVC_DISP  = 3'd2,
      SYS_SVC_PUTC  = 3'd3,
      SYS_SVC_PAUSE = 3'd4
   } sys_svc_t;

   // Map a $v0 value onto a service. The codes are passed in so that a
   // parameterised instance can renumber its services.
   function automatic sys_svc_t decode_service(
      input logic [SYS_DATA_W-1:0] code,
      input logic [SYS_DATA_W-1:0] code_halt,
      input logic [SYS_DATA_W-1:0] code_disp,
      input logic [SYS_DATA_W-1:0] code_putc,
      input logic [SYS_DATA_W-1:0] code_pause
   );
      sys_svc_t svc;
      svc = SYS_SVC_UNK;
      if (code == code_halt) begin
         svc = SYS_SVC_HALT;
      end else if (code == code_disp) begin
         svc = SYS_SVC_DISP;
      end else if (code == code_putc) begin
         svc = SYS_SVC_PUTC;
      end else if (code == code_pause) begin
         svc = SYS_SVC_PAUSE;
      end
      return svc;
   endfunction

endpackage

// File: rtl/syscall_responder_if.sv
// ----------------------------------------------------------------------------
// syscall_responder_if
// Purpose : bundles the signals between the core and the SYSCALL responder.
//           "master" is the core side (decoder, register file, char sink),
//           "slave" is the responder itself.
// Signals :
//   syscall_en  core -> resp   SYSCALL decoded, held while stall=1
//   v0, a0      core -> resp   register $2 / $4 read data
//   resume      core -> resp   one-cycle pulse releasing HALT
//   chr_ready   sink -> resp   char sink accepts the byte
//   stall       resp -> core   freezes PC and all architectural writes
//   halted      resp -> core   high while halted
//   disp_val    resp -> core   display register
//   disp_upd    resp -> core   one-cycle pulse on display update
//   chr_data    resp -> sink   char byte
//   chr_valid   resp -> sink   char byte valid, held until chr_ready
//   unk_cnt     resp -> core   saturating count of unknown service codes
// ----------------------------------------------------------------------------
interface syscall_responder_if;
   import syscall_responder_pkg::*;

   logic                  syscall_en;
   logic [SYS_DATA_W-1:0] v0;
   logic [SYS_DATA_W-1:0] a0;
   logic                  resume;
   logic                  stall;
   logic                  halted;
   logic [SYS_DATA_W-1:0] disp_val;
   logic                  disp_upd;
   logic [SYS_CHAR_W-1:0] chr_data;
   logic                  chr_valid;
   logic                  chr_ready;
   logic [SYS_UNK_W-1:0]  unk_cnt;

   modport master (
      output syscall_en, v0, a0, resume, chr_ready,
      input  stall, halted, disp_val, disp_upd, chr_data, chr_valid, unk_cnt
   );

   modport slave (
      input  syscall_en, v0, a0, resume, chr_ready,
      output stall, halted, disp_val, disp_upd, chr_data, chr_valid, unk_cnt
   );

endinterface

// File: rtl/syscall_responder.sv
// ----------------------------------------------------------------------------
// syscall_responder
// Purpose : service end of the SYSCALL path. When the decoder raises
//           syscall_en in IDLE, the service chosen by $v0 runs with argument
//           $a0: halt until resume, latch the display register, emit a
//           character on a valid/ready stream, or pause for $a0 cycles.
//           Unknown codes are counted and otherwise behave as NOP. While a
//           multi-cycle service runs, stall freezes the single-cycle core;
//           a one-cycle DONE state then lets the PC step past the SYSCALL.
// Ports   :
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of syscall_responder_if (handshake/data signals)
// ----------------------------------------------------------------------------
module syscall_responder
   import syscall_responder_pkg::*;
#(
   parameter logic [SYS_DATA_W-1:0] CODE_HALT  = SYS_CODE_HALT,
   parameter logic [SYS_DATA_W-1:0] CODE_DISP  = SYS_CODE_DISP,
   parameter logic [SYS_DATA_W-1:0] CODE_PUTC  = SYS_CODE_PUTC,
   parameter logic [SYS_DATA_W-1:0] CODE_PAUSE = SYS_CODE_PAUSE,
   parameter int                    PAUSE_W    = SYS_PAUSE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   syscall_responder_if.slave bus
);

   sys_state_t            state;
   sys_state_t            state_nxt;
   sys_svc_t              svc;
   logic                  accept;
   logic                  stall;
   logic                  pause_zero;
   logic                  chr_fire;
   logic [PAUSE_W-1:0]    pause_cnt;
   logic                  halted_q;
   logic [SYS_DATA_W-1:0] disp_val_q;
   logic                  disp_upd_q;
   logic [SYS_CHAR_W-1:0] chr_data_q;
   logic                  chr_valid_q;
   logic [SYS_UNK_W-1:0]  unk_cnt_q;

   // Decode the request and work out the next state and the stall output.
   // A request is only looked at in IDLE; DONE deliberately ignores
   // syscall_en so the same SYSCALL is not serviced twice before the PC
   // has moved on. Stall is combinational so the accept cycle itself is
   // already frozen for every multi-cycle service.
   always_comb begin
      svc        = decode_service(bus.v0, CODE_HALT, CODE_DISP, CODE_PUTC, CODE_PAUSE);
      accept     = (state == SYS_ST_IDLE) && bus.syscall_en;
      pause_zero = (bus.a0[PAUSE_W-1:0] == '0);
      chr_fire   = chr_valid_q && bus.chr_ready;
      state_nxt  = state;
      stall      = 1'b0;
      case (state)
         SYS_ST_IDLE: begin
            if (accept) begin
               case (svc)
                  SYS_SVC_HALT: begin
                     stall     = 1'b1;
                     state_nxt = SYS_ST_HALT;
                  end
                  SYS_SVC_PUTC: begin
                     stall     = 1'b1;
                     state_nxt = SYS_ST_PRINT;
                  end
                  SYS_SVC_PAUSE: begin
                     stall     = 1'b1;
                     state_nxt = pause_zero ? SYS_ST_DONE : SYS_ST_PAUSE;
                  end
                  default: begin
                     state_nxt = SYS_ST_IDLE;
                  end
               endcase
            end
         end
         SYS_ST_PAUSE: begin
            stall = 1'b1;
            // The <= guards against ever wrapping if the count were 0 here
            if (pause_cnt <= PAUSE_W'(1)) begin
               state_nxt = SYS_ST_DONE;
            end
         end
         SYS_ST_PRINT: begin
            stall = 1'b1;
            if (chr_fire) begin
               state_nxt = SYS_ST_DONE;
            end
         end
         SYS_ST_HALT: begin
            stall = 1'b1;
            if (bus.resume) begin
               state_nxt = SYS_ST_DONE;
            end
         end
         SYS_ST_DONE: begin
            state_nxt = SYS_ST_IDLE;
         end
         default: begin
            state_nxt = SYS_ST_IDLE;
         end
      endcase
   end

   // State register. Reset aborts whatever service was in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SYS_ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Pause counter: loaded from the low $a0 bits on acceptance (upper bits
   // are ignored), then counts down once per PAUSE cycle. Leaving PAUSE at
   // a count of 1 gives N stall cycles in PAUSE plus the accept cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pause_cnt <= '0;
      end else if (accept && (svc == SYS_SVC_PAUSE)) begin
         pause_cnt <= bus.a0[PAUSE_W-1:0];
      end else if (state == SYS_ST_PAUSE) begin
         pause_cnt <= pause_cnt - PAUSE_W'(1);
      end
   end

   // The halted flag is registered from the next state so that it is high
   // for exactly the cycles the FSM sits in HALT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= (state_nxt == SYS_ST_HALT);
      end
   end

   // Display latch. This service never stalls; the update strobe is high
   // only in the cycle right after the latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_val_q <= '0;
         disp_upd_q <= 1'b0;
      end else begin
         disp_upd_q <= accept && (svc == SYS_SVC_DISP);
         if (accept && (svc == SYS_SVC_DISP)) begin
            disp_val_q <= bus.a0;
         end
      end
   end

   // Character output register. The byte is captured on acceptance and
   // left untouched while valid is high, so the sink sees a stable value
   // until it takes it. A reset drops any byte that was still pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chr_data_q  <= '0;
         chr_valid_q <= 1'b0;
      end else if (accept && (svc == SYS_SVC_PUTC)) begin
         chr_data_q  <= bus.a0[SYS_CHAR_W-1:0];
         chr_valid_q <= 1'b1;
      end else if ((state == SYS_ST_PRINT) && chr_fire) begin
         chr_valid_q <= 1'b0;
      end
   end

   // Unknown-code counter. It sticks at all-ones instead of wrapping so a
   // runaway program still shows that something went wrong.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unk_cnt_q <= '0;
      end else if (accept && (svc == SYS_SVC_UNK) && (unk_cnt_q != '1)) begin
         unk_cnt_q <= unk_cnt_q + SYS_UNK_W'(1);
      end
   end

   assign bus.stall     = stall;
   assign bus.halted    = halted_q;
   assign bus.disp_val  = disp_val_q;
   assign bus.disp_upd  = disp_upd_q;
   assign bus.chr_data  = chr_data_q;
   assign bus.chr_valid = chr_valid_q;
   assign bus.unk_cnt   = unk_cnt_q;

endmodule
